// File: rtl/z_sum_window.sv
// z_sum_window: accumulates WINDOW accepted sum samples into one widened total on a valid/ready output.
// Optional sticky odd-sample flag on port parity_err when Z_SUM_PARITY_CHECK_EN is defined.
module z_sum_window #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 4,
  parameter int ACC_W  = (WINDOW == 1) ? WIDTH : WIDTH + $clog2(WINDOW),
  parameter int DROP_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WIDTH-1:0]              in0,
  input  logic                          out_ready,
  output logic                          in_ready,
  output logic [ACC_W-1:0]              out,
  output logic                          out_valid,
  output logic [$clog2(WINDOW+1)-1:0]   fill,
  output logic [DROP_W-1:0]             drops
`ifdef Z_SUM_PARITY_CHECK_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int FILL_W = $clog2(WINDOW+1);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(WINDOW-1);
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [ACC_W-1:0]    acc_r, acc_nxt_s, out_nxt_s, sum_s;
  logic [FILL_W-1:0]   fill_nxt_s;
  logic [DROP_W-1:0]   drops_nxt_s;
  logic                hs_s, accept_s, drop_s, last_s;

  // A handshake frees the holding register, so a sample in that same cycle is accepted.
  assign hs_s     = out_valid & out_ready;
  assign in_ready = (state_r == ACCUM) | hs_s;
  assign accept_s = en & in_ready;
  assign drop_s   = en & ~in_ready;
  assign sum_s    = acc_r + ACC_W'(in0);
  assign last_s   = (fill == LAST_FILL);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; acc and fill are already zero in HOLD, so a sample there starts a fresh window
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (accept_s && last_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (accept_s && last_s) begin
          state_nxt_s = HOLD;
        end else if (hs_s) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // Datapath next values: accumulate, close a window, count drops
  always_comb begin
    acc_nxt_s   = acc_r;
    fill_nxt_s  = fill;
    out_nxt_s   = out;
    drops_nxt_s = drops;
    if (accept_s) begin
      if (last_s) begin
        acc_nxt_s  = {ACC_W{1'b0}};
        fill_nxt_s = {FILL_W{1'b0}};
        out_nxt_s  = sum_s;
      end else begin
        acc_nxt_s  = sum_s;
        fill_nxt_s = fill + FILL_W'(1'b1);
      end
    end else begin
      acc_nxt_s  = acc_r;
      fill_nxt_s = fill;
    end
    if (drop_s && (drops != DROP_MAX)) begin
      drops_nxt_s = drops + DROP_W'(1'b1);
    end else begin
      drops_nxt_s = drops;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r     <= {ACC_W{1'b0}};
      fill      <= {FILL_W{1'b0}};
      out       <= {ACC_W{1'b0}};
      out_valid <= 1'b0;
      drops     <= {DROP_W{1'b0}};
    end else begin
      acc_r     <= acc_nxt_s;
      fill      <= fill_nxt_s;
      out       <= out_nxt_s;
      out_valid <= (state_nxt_s == HOLD);
      drops     <= drops_nxt_s;
    end
  end

`ifdef Z_SUM_PARITY_CHECK_EN
  // Upstream sums two identical registers, so any odd accepted sample marks corruption
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_err | (accept_s & in0[0]);
    end
  end

`ifdef FORMAL
  z_sum_window_parity_chk u_parity_chk (
    .clk        (clk),
    .rst        (rst),
    .parity_err (parity_err)
  );
`endif
`endif

endmodule

`ifdef Z_SUM_PARITY_CHECK_EN
`ifdef FORMAL
module z_sum_window_parity_chk (
  input logic clk,
  input logic rst,
  input logic parity_err
);
  // Out of reset the flag must never rise
  always @(posedge clk) begin
    if (rst) begin
      assert (!parity_err);
    end
  end
endmodule
`endif
`endif

// File: tb/tb_z_sum_window.sv
// Directed scoreboard bench for z_sum_window with WIDTH=8, WINDOW=4.
module tb_z_sum_window;
  localparam int WIDTH  = 8;
  localparam int WINDOW = 4;
  localparam int ACC_W  = 10;
  localparam int DROP_W = 8;
  localparam int FILL_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [WIDTH-1:0]  in0;
  logic              out_ready;
  logic              in_ready;
  logic [ACC_W-1:0]  out;
  logic              out_valid;
  logic [FILL_W-1:0] fill;
  logic [DROP_W-1:0] drops;
`ifdef Z_SUM_PARITY_CHECK_EN
  logic              parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  z_sum_window #(.WIDTH(WIDTH), .WINDOW(WINDOW), .ACC_W(ACC_W), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in0       (in0),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .fill      (fill),
    .drops     (drops)
`ifdef Z_SUM_PARITY_CHECK_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    en  = 1'b1;
    in0 = v;
    tick();
    en  = 1'b0;
  endtask

  task automatic check_total(input string tag);
    int e;
    chk({tag, "_valid"}, out_valid, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_out"}, out, e);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; in0 = '0; out_ready = 1'b0;
    #12;
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_drops", drops, 0);
    rst = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // Basic window 2,4,6,8
    out_ready = 1'b1;
    send(8'd2); chk("t1_fill1", fill, 1); chk("t1_nvalid", out_valid, 0);
    send(8'd4); chk("t1_fill2", fill, 2);
    send(8'd6); chk("t1_fill3", fill, 3);
    exp_q.push_back(20);
    send(8'd8); chk("t1_fill0", fill, 0);
    check_total("t1");
    tick();
    chk("t1_one_cycle", out_valid, 0);

    // 254 x4 with gaps; last one left pending
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        out_ready = 1'b0;
        exp_q.push_back(1016);
      end
      send(8'd254);
      if (i < 3) begin
        tick(); tick();
        chk("t2_fill_hold", fill, i + 1);
      end
    end
    check_total("t2");

    // Drops while pending, then handshake with a same-cycle sample
    chk("t3_in_ready0", in_ready, 0);
    send(8'd10); send(8'd12); send(8'd14);
    chk("t3_drops", drops, 3);
    chk("t3_out_stable", out, 1016);
    chk("t3_valid_held", out_valid, 1);
    chk("t3_fill0", fill, 0);
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready1", in_ready, 1);
    send(8'd16);
    chk("t3_hs_valid", out_valid, 0);
    chk("t3_hs_fill", fill, 1);
    send(8'd1); send(8'd1);
    exp_q.push_back(19);
    send(8'd1);
    check_total("t3_acc16");
    tick();

    // Asynchronous reset mid-window
    send(8'd2); send(8'd2);
    chk("t4_fill2", fill, 2);
    rst = 1'b0;
    #2;
    chk("t4_rst_fill", fill, 0);
    chk("t4_rst_valid", out_valid, 0);
    rst = 1'b1;
    send(8'd6); send(8'd6); send(8'd6);
    exp_q.push_back(24);
    send(8'd6);
    check_total("t4");
    tick();

    // Drop counter saturation, then reset while holding
    out_ready = 1'b0;
    send(8'd1); send(8'd1); send(8'd1);
    exp_q.push_back(4);
    send(8'd1);
    check_total("t5");
    en = 1'b1; in0 = 8'd9;
    repeat (300) tick();
    en = 1'b0;
    chk("t5_drops_sat", drops, 255);
    chk("t5_out_stable", out, 4);
    rst = 1'b0;
    #2;
    chk("t5_rst_drops", drops, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_out", out, 0);
    rst = 1'b1;
    tick();
    chk("t5_in_ready", in_ready, 1);
    chk("t5_no_spurious", out_valid, 0);

`ifdef Z_SUM_PARITY_CHECK_EN
    out_ready = 1'b1;
    send(8'd2); chk("t6_par_clean", parity_err, 0);
    send(8'd3); chk("t6_par_set", parity_err, 1);
    send(8'd4);
    exp_q.push_back(15);
    send(8'd6);
    check_total("t6");
    chk("t6_par_sticky", parity_err, 1);
    tick();
    chk("t6_par_sticky2", parity_err, 1);
    rst = 1'b0;
    #2;
    chk("t6_par_rst", parity_err, 0);
    rst = 1'b1;
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/z_sum_window.md
Name: z_sum_window

Overview:
- Downstream consumer of the z_sum adder stream: takes the WIDTH-bit sum and its enable strobe, and accumulates WINDOW consecutive accepted samples into one widened total.
- Presents each total on a valid/ready output handshake.
- Samples arriving while a total is held unacknowledged are dropped and counted, so upstream never needs backpressure.

Parameters:
- WIDTH, 8, width of the incoming sum samples (matches the upstream adder).
- WINDOW, 4, number of samples per total; legal range 1..256.
- ACC_W, WIDTH+$clog2(WINDOW) (WIDTH when WINDOW=1), width of the accumulator and the output total.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; all state clears while low.
- en  input  1  sample strobe; in0 is valid in cycles where en=1.
- in0  input  WIDTH  sum sample from the upstream stage.
- out_ready  input  1  downstream accepts the total when out_valid=1.
- in_ready  output  1  status only: 1 means a sample with en=1 this cycle is accepted.
- out  output  ACC_W  completed window total.
- out_valid  output  1  out holds an unacknowledged total.
- fill  output  $clog2(WINDOW+1)  number of samples in the current partial window.
- drops  output  DROP_W  saturating count of samples dropped.

Behaviour:
- Reset (rst=0, asynchronous) clears the following, regardless of the clock:
  - state=ACCUM, acc=0, fill=0, out=0, out_valid=0, drops=0.
  - Outputs read 0 for the whole time reset is held; in_ready=1 after release.
- Accepted sample: en=1 and in_ready=1.
- in_ready = (state==ACCUM) | (out_valid & out_ready). Combinational from registered state and out_ready.
- ACCUM state, on an accepted sample:
  - acc <= acc + in0, with in0 zero-extended to ACC_W; fill <= fill+1.
  - If fill==WINDOW-1: out <= acc+in0, out_valid <= 1, acc <= 0, fill <= 0, go to HOLD.
  - Latency: the total is visible on the clock edge that accepts the last sample, i.e. one cycle after that sample is presented.
- No en in ACCUM: all state holds.
- HOLD state, out_valid=1:
  - out must be stable until handshake.
  - Handshake = out_valid & out_ready at a clock edge.
  - Handshake without en: out_valid <= 0, go to ACCUM.
  - Handshake with en in the same cycle: the sample is accepted as the first sample of the next window (acc <= in0, fill <= 1), out_valid <= 0, go to ACCUM.
  - With WINDOW=1, that sample instead produces a new total immediately (out <= in0, out_valid stays 1, stay in HOLD). Back-to-back throughput is one total per cycle.
- HOLD with en=1 and out_ready=0: sample dropped; drops <= drops+1, saturating at 2^DROP_W-1. acc and fill are unchanged.
- Arithmetic: acc never overflows. The maximum value WINDOW*(2^WIDTH-1) fits in ACC_W.
- out_ready is ignored when out_valid=0.
- Reset asserted mid-window or in HOLD discards the partial window and the pending total, with no spurious out_valid.

Optional Feature:
- Macro: Z_SUM_PARITY_CHECK_EN.
- With the macro defined:
  - Adds output port parity_err (1 bit).
  - parity_err is a sticky flag set on any accepted sample with in0[0]==1; the upstream sum of two identical registers is always even.
  - Cleared only by reset. The offending sample is still accumulated normally.
  - Under FORMAL, asserts !parity_err after the initial state.
- Without the macro: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- WIDTH=8, WINDOW=4, out_ready=1; accepted samples 2,4,6,8 on consecutive cycles -> out=20, out_valid=1 for exactly one cycle, the cycle after the sample 8 is presented; fill sequence 1,2,3,0.
- Four samples of 254, with en gaps between them -> out=1016 (fits ACC_W=10); fill holds its value during the gaps.
- Total pending with out_ready=0, three en pulses with 10,12,14 -> drops=3, out unchanged. Then out_ready=1 with en and in0=16 in the same cycle -> handshake completes, fill=1, acc=16.
- Two samples (2,2) accepted, then rst pulsed low between clock edges -> fill=0, out_valid=0 immediately. Next four samples of 6 -> out=24.
- Hold out_ready=0 and drive 300 dropped samples -> drops saturates at 255; reset -> 0.
- Z_SUM_PARITY_CHECK_EN defined; samples 2,3,4,6 -> parity_err rises after the cycle accepting 3 and stays high; out=15; cleared only by reset.
